// File: rtl/battle_turn_controller.sv
// Two-player battleships turn sequencer: holds both fleets' segment placements,
// resolves the active player's shots against the opponent fleet, tracks per-segment
// hit bits and sticky per-ship sunk flags, and declares a winner once a fleet is sunk.
// Latency: shot handshake in T, result_valid in T+2, shot_ready again in T+3 (1 shot / 3 cycles).
// Backpressure: shot_ready is a decode of the registered state; it is high only while
// waiting for a shot, never in SETUP, CHECK, REPORT or OVER.
//
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   place_*                      segment placement writes (SETUP only)
//   start                        begin the game once every segment has been placed
//   shot_valid/shot_ready/shot_* shot handshake from the active player
//   turn                         active player
//   result_*                     registered result of the last resolved shot
//   sunk_p0, sunk_p1             sticky per-ship sunk flags per fleet
//   game_over, winner            end-of-game status
module battle_turn_controller #(
    parameter int  NUM_SHIPS = 2,
    parameter int  SHIP_SIZE = 3,
    parameter int  COORD_W   = 3,
    localparam int SHIP_W    = (NUM_SHIPS > 1) ? $clog2(NUM_SHIPS) : 1,
    localparam int SEG_W     = (SHIP_SIZE > 1) ? $clog2(SHIP_SIZE) : 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 place_valid,
    input  logic                 place_player,
    input  logic [SHIP_W-1:0]    place_ship,
    input  logic [SEG_W-1:0]     place_seg,
    input  logic [COORD_W-1:0]   place_row,
    input  logic [COORD_W-1:0]   place_col,
    input  logic                 start,
    input  logic                 shot_valid,
    output logic                 shot_ready,
    input  logic [COORD_W-1:0]   shot_row,
    input  logic [COORD_W-1:0]   shot_col,
    output logic                 turn,
    output logic                 result_valid,
    output logic                 result_hit,
    output logic                 result_repeat,
    output logic                 result_sunk,
    output logic [SHIP_W-1:0]    result_ship,
    output logic [NUM_SHIPS-1:0] sunk_p0,
    output logic [NUM_SHIPS-1:0] sunk_p1,
    output logic                 game_over,
    output logic                 winner
);

    typedef enum logic [2:0] {
        ST_SETUP  = 3'd0,
        ST_SHOT   = 3'd1,
        ST_CHECK  = 3'd2,
        ST_REPORT = 3'd3,
        ST_OVER   = 3'd4
    } state_e;

    // One bit per segment of one fleet.
    typedef logic [NUM_SHIPS-1:0][SHIP_SIZE-1:0] seg_mask_t;

    state_e state_q, state_d;

    // Fleet storage, indexed [player][ship][segment].
    logic [1:0][NUM_SHIPS-1:0][SHIP_SIZE-1:0][COORD_W-1:0] row_q;
    logic [1:0][NUM_SHIPS-1:0][SHIP_SIZE-1:0][COORD_W-1:0] col_q;
    seg_mask_t [1:0]            placed_q;
    seg_mask_t [1:0]            hit_q;
    logic [1:0][NUM_SHIPS-1:0]  sunk_q;

    logic [COORD_W-1:0] shot_row_q;
    logic [COORD_W-1:0] shot_col_q;
    logic               turn_q;
    logic               game_over_q;
    logic               winner_q;
    logic               result_hit_q;
    logic               result_repeat_q;
    logic               result_sunk_q;
    logic [SHIP_W-1:0]  result_ship_q;

    logic               opp;
    logic               all_placed;
    logic               opp_all_sunk;
    logic               place_in_range;
    seg_mask_t          match;
    seg_mask_t          hit_new;
    logic [NUM_SHIPS-1:0] full;
    logic               any_match;
    logic               any_fresh;
    logic [SHIP_W-1:0]  first_ship;

    assign opp            = ~turn_q;
    assign all_placed     = &placed_q;
    // Read in REPORT, after CHECK has already folded this shot into sunk_q.
    assign opp_all_sunk   = &sunk_q[opp];
    // Index fields can be wider than the ship/segment counts; such writes are dropped.
    assign place_in_range = (int'(place_ship) < NUM_SHIPS) && (int'(place_seg) < SHIP_SIZE);

    // Shot resolution against the opponent fleet. Overlapping segments can all match.
    always_comb begin
        match      = '0;
        full       = '0;
        first_ship = '0;
        for (int s = 0; s < NUM_SHIPS; s++) begin
            for (int g = 0; g < SHIP_SIZE; g++) begin
                match[s][g] = (row_q[opp][s][g] == shot_row_q) &&
                              (col_q[opp][s][g] == shot_col_q);
            end
        end
        hit_new = hit_q[opp] | match;
        for (int s = 0; s < NUM_SHIPS; s++) begin
            full[s] = &hit_new[s];
        end
        // Walk downwards so the lowest matching ship index wins.
        for (int s = NUM_SHIPS - 1; s >= 0; s--) begin
            if (|match[s]) begin
                first_ship = SHIP_W'(s);
            end
        end
        any_match = |match;
        any_fresh = |(match & ~hit_q[opp]);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_SETUP;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_SETUP:  if (start && all_placed) state_d = ST_SHOT;
            ST_SHOT:   if (shot_valid) state_d = ST_CHECK;
            ST_CHECK:  state_d = ST_REPORT;
            ST_REPORT: state_d = opp_all_sunk ? ST_OVER : ST_SHOT;
            ST_OVER:   state_d = ST_OVER;
            default:   state_d = ST_SETUP;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            row_q           <= '0;
            col_q           <= '0;
            placed_q        <= '0;
            hit_q           <= '0;
            sunk_q          <= '0;
            shot_row_q      <= '0;
            shot_col_q      <= '0;
            turn_q          <= 1'b0;
            game_over_q     <= 1'b0;
            winner_q        <= 1'b0;
            result_hit_q    <= 1'b0;
            result_repeat_q <= 1'b0;
            result_sunk_q   <= 1'b0;
            result_ship_q   <= '0;
        end else begin
            case (state_q)
                ST_SETUP: begin
                    if (place_valid && place_in_range) begin
                        row_q[place_player][place_ship][place_seg]    <= place_row;
                        col_q[place_player][place_ship][place_seg]    <= place_col;
                        placed_q[place_player][place_ship][place_seg] <= 1'b1;
                    end
                    if (start && all_placed) begin
                        turn_q <= 1'b0;
                    end
                end
                ST_SHOT: begin
                    if (shot_valid) begin
                        shot_row_q <= shot_row;
                        shot_col_q <= shot_col;
                    end
                end
                ST_CHECK: begin
                    hit_q[opp]      <= hit_new;
                    sunk_q[opp]     <= sunk_q[opp] | full;
                    result_hit_q    <= any_fresh;
                    result_repeat_q <= any_match & ~any_fresh;
                    result_sunk_q   <= |(full & ~sunk_q[opp]);
                    result_ship_q   <= first_ship;
                end
                ST_REPORT: begin
                    if (opp_all_sunk) begin
                        game_over_q <= 1'b1;
                        winner_q    <= turn_q;
                    end else begin
                        turn_q <= ~turn_q;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign shot_ready    = (state_q == ST_SHOT);
    assign result_valid  = (state_q == ST_REPORT);
    assign turn          = turn_q;
    assign result_hit    = result_hit_q;
    assign result_repeat = result_repeat_q;
    assign result_sunk   = result_sunk_q;
    assign result_ship   = result_ship_q;
    assign sunk_p0       = sunk_q[0];
    assign sunk_p1       = sunk_q[1];
    assign game_over     = game_over_q;
    assign winner        = winner_q;

endmodule

// File: tb/tb_battle_turn_controller.sv
module tb_battle_turn_controller;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       place_valid;
    logic       place_player;
    logic [0:0] place_ship;
    logic [1:0] place_seg;
    logic [2:0] place_row;
    logic [2:0] place_col;
    logic       start;
    logic       shot_valid;
    logic       shot_ready;
    logic [2:0] shot_row;
    logic [2:0] shot_col;
    logic       turn;
    logic       result_valid;
    logic       result_hit;
    logic       result_repeat;
    logic       result_sunk;
    logic [0:0] result_ship;
    logic [1:0] sunk_p0;
    logic [1:0] sunk_p1;
    logic       game_over;
    logic       winner;

    battle_turn_controller dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .place_valid  (place_valid),
        .place_player (place_player),
        .place_ship   (place_ship),
        .place_seg    (place_seg),
        .place_row    (place_row),
        .place_col    (place_col),
        .start        (start),
        .shot_valid   (shot_valid),
        .shot_ready   (shot_ready),
        .shot_row     (shot_row),
        .shot_col     (shot_col),
        .turn         (turn),
        .result_valid (result_valid),
        .result_hit   (result_hit),
        .result_repeat(result_repeat),
        .result_sunk  (result_sunk),
        .result_ship  (result_ship),
        .sunk_p0      (sunk_p0),
        .sunk_p1      (sunk_p1),
        .game_over    (game_over),
        .winner       (winner)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference game state: coordinates per [player][ship][segment].
    int m_row  [2][2][3];
    int m_col  [2][2][3];
    bit m_hit  [2][2][3];
    bit m_sunk [2][2];
    bit m_turn;
    bit m_over;
    bit m_winner;
    bit exp_hit;
    bit exp_rep;
    bit exp_sunk;
    int exp_ship;

    // Observed shot: [12]rv@T+1 [11]rdy@T+1 [10]rv@T+2 [9]rdy@T+2 [8]hit [7]repeat
    // [6]sunk [5]ship [4:3]sunk_p0 [2:1]sunk_p1 [0]game_over@T+2
    logic [12:0] cap_res;
    // After the shot (T+3): [4]rv [3]shot_ready [2]turn [1]game_over [0]winner
    logic [4:0]  cap_post;
    logic [12:0] all_out;

    // Standard fleets. P0: ship0 row 7 cols 0..2, ship1 row 5 cols 5..7.
    // P1: ship0 row 0 cols 0..2, ship1 col 5 rows 2..4.
    int std_r [12] = '{7, 7, 7, 5, 5, 5, 0, 0, 0, 2, 3, 4};
    int std_c [12] = '{0, 1, 2, 5, 6, 7, 0, 1, 2, 5, 5, 5};

    function automatic void model_clear();
        for (int p = 0; p < 2; p++)
            for (int s = 0; s < 2; s++) begin
                m_sunk[p][s] = 1'b0;
                for (int g = 0; g < 3; g++) begin
                    m_row[p][s][g] = 0;
                    m_col[p][s][g] = 0;
                    m_hit[p][s][g] = 1'b0;
                end
            end
        m_turn   = 1'b0;
        m_over   = 1'b0;
        m_winner = 1'b0;
    endfunction

    // Game rules: resolve a shot by the player to move against the other fleet.
    function automatic void model_shot(input int r, input int c);
        int  o;
        bit  any;
        bit  found;
        bit  all_hit;
        bit  fleet_gone;
        o        = 1 - int'(m_turn);
        exp_hit  = 1'b0;
        exp_sunk = 1'b0;
        exp_ship = 0;
        any      = 1'b0;
        found    = 1'b0;
        for (int s = 0; s < 2; s++)
            for (int g = 0; g < 3; g++)
                if (m_row[o][s][g] == r && m_col[o][s][g] == c) begin
                    any = 1'b1;
                    if (!found) begin
                        exp_ship = s;
                        found    = 1'b1;
                    end
                    if (!m_hit[o][s][g]) exp_hit = 1'b1;
                    m_hit[o][s][g] = 1'b1;
                end
        exp_rep    = any && !exp_hit;
        fleet_gone = 1'b1;
        for (int s = 0; s < 2; s++) begin
            all_hit = m_hit[o][s][0] && m_hit[o][s][1] && m_hit[o][s][2];
            if (all_hit && !m_sunk[o][s]) begin
                exp_sunk     = 1'b1;
                m_sunk[o][s] = 1'b1;
            end
            if (!m_sunk[o][s]) fleet_gone = 1'b0;
        end
        if (fleet_gone) begin
            m_over   = 1'b1;
            m_winner = m_turn;
        end else begin
            m_turn = ~m_turn;
        end
    endfunction

    function automatic logic [12:0] exp_res();
        return {1'b0, 1'b0, 1'b1, 1'b0, exp_hit, exp_rep, exp_sunk, 1'(exp_ship),
                m_sunk[0][1], m_sunk[0][0], m_sunk[1][1], m_sunk[1][0], 1'b0};
    endfunction

    function automatic logic [4:0] exp_post();
        return {1'b0, ~m_over, m_turn, m_over, m_winner};
    endfunction

    task automatic do_reset();
        reset_n     = 1'b0;
        place_valid = 1'b0;
        start       = 1'b0;
        shot_valid  = 1'b0;
        model_clear();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic place(input int p, input int s, input int g, input int r, input int c,
                         input bit with_start);
        place_valid  = 1'b1;
        place_player = p[0];
        place_ship   = s[0:0];
        place_seg    = g[1:0];
        place_row    = r[2:0];
        place_col    = c[2:0];
        start        = with_start;
        @(negedge clk);
        place_valid = 1'b0;
        start       = 1'b0;
        if (s < 2 && g < 3) begin
            m_row[p][s][g] = r;
            m_col[p][s][g] = c;
        end
    endtask

    task automatic place_std(input int upto);
        for (int i = 0; i < upto; i++)
            place(i / 6, (i / 3) % 2, i % 3, std_r[i], std_c[i], 1'b0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Drives one shot and records the DUT response cycle by cycle; no checking here.
    task automatic do_shot(input int r, input int c);
        int   n;
        logic rv1;
        logic rdy1;
        n = 0;
        while (shot_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (shot_ready !== 1'b1) begin
            cap_res  = '1;
            cap_post = '1;
            return;
        end
        shot_valid = 1'b1;
        shot_row   = r[2:0];
        shot_col   = c[2:0];
        @(negedge clk);
        shot_valid = 1'b0;
        rv1        = result_valid;
        rdy1       = shot_ready;
        @(negedge clk);
        cap_res = {rv1, rdy1, result_valid, shot_ready, result_hit, result_repeat, result_sunk,
                   result_ship, sunk_p0, sunk_p1, game_over};
        @(negedge clk);
        cap_post = {result_valid, shot_ready, turn, game_over, winner};
    endtask

    task automatic test_reset();
        reset_n     = 1'b1;
        place_valid = 1'b0;
        place_player = 1'b0;
        place_ship  = '0;
        place_seg   = '0;
        place_row   = '0;
        place_col   = '0;
        start       = 1'b0;
        shot_valid  = 1'b0;
        shot_row    = '0;
        shot_col    = '0;
        model_clear();
        #2 reset_n = 1'b0;
        #1;
        all_out = {shot_ready, turn, result_valid, result_hit, result_repeat, result_sunk,
                   result_ship, sunk_p0, sunk_p1, game_over, winner};
        checks++;
        if (all_out !== 13'd0) begin
            failures++;
            $display("FAIL reset_async got=%b exp=0", all_out);
        end
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        all_out = {shot_ready, turn, result_valid, result_hit, result_repeat, result_sunk,
                   result_ship, sunk_p0, sunk_p1, game_over, winner};
        checks++;
        if (all_out !== 13'd0) begin
            failures++;
            $display("FAIL reset_release got=%b exp=0", all_out);
        end
    endtask

    task automatic test_setup_gating();
        place_std(11);
        place(1, 1, 3, 4, 5, 1'b0);
        pulse_start();
        checks++;
        if (shot_ready !== 1'b0) begin
            failures++;
            $display("FAIL gate_incomplete shot_ready=%b exp=0", shot_ready);
        end
        place(1, 1, 2, std_r[11], std_c[11], 1'b1);
        checks++;
        if (shot_ready !== 1'b0) begin
            failures++;
            $display("FAIL gate_same_cycle shot_ready=%b exp=0", shot_ready);
        end
        pulse_start();
        checks++;
        if ({shot_ready, turn} !== 2'b10) begin
            failures++;
            $display("FAIL gate_start ready_turn=%b exp=10", {shot_ready, turn});
        end
    endtask

    task automatic test_miss();
        do_shot(6, 6);
        model_shot(6, 6);
        checks++;
        if (cap_res !== exp_res()) begin
            failures++;
            $display("FAIL miss_res got=%b exp=%b", cap_res, exp_res());
        end
        checks++;
        if ({cap_res[10], cap_res[8], cap_res[7], cap_post[3], cap_post[2]} !== 5'b10011) begin
            failures++;
            $display("FAIL miss_fixed got=%b exp=10011",
                     {cap_res[10], cap_res[8], cap_res[7], cap_post[3], cap_post[2]});
        end
        checks++;
        if (cap_post !== exp_post()) begin
            failures++;
            $display("FAIL miss_post got=%b exp=%b", cap_post, exp_post());
        end
    endtask

    task automatic test_hit_repeat();
        int tr [4] = '{1, 2, 1, 2};
        int tc [4] = '{1, 5, 1, 5};
        for (int i = 0; i < 4; i++) begin
            do_shot(tr[i], tc[i]);
            model_shot(tr[i], tc[i]);
            checks++;
            if (cap_res !== exp_res() || cap_post !== exp_post()) begin
                failures++;
                $display("FAIL hitrep_%0d got=%b/%b exp=%b/%b", i, cap_res, cap_post,
                         exp_res(), exp_post());
            end
        end
        // Last shot is the repeat at (2,5); the one two shots earlier was the fresh hit.
        checks++;
        if ({cap_res[8], cap_res[7], cap_res[6], cap_res[5], cap_res[2:1], cap_post[2]} !== 7'b0101001) begin
            failures++;
            $display("FAIL repeat_fixed got=%b exp=0101001",
                     {cap_res[8], cap_res[7], cap_res[6], cap_res[5], cap_res[2:1], cap_post[2]});
        end
    endtask

    task automatic test_sink();
        int tr [6] = '{1, 0, 1, 0, 1, 0};
        int tc [6] = '{1, 0, 1, 1, 1, 2};
        for (int i = 0; i < 6; i++) begin
            do_shot(tr[i], tc[i]);
            model_shot(tr[i], tc[i]);
            checks++;
            if (cap_res !== exp_res() || cap_post !== exp_post()) begin
                failures++;
                $display("FAIL sink_%0d got=%b/%b exp=%b/%b", i, cap_res, cap_post,
                         exp_res(), exp_post());
            end
            if (i == 3) begin
                checks++;
                if ({cap_res[8], cap_res[6]} !== 2'b10) begin
                    failures++;
                    $display("FAIL sink_second hit_sunk=%b exp=10", {cap_res[8], cap_res[6]});
                end
            end
        end
        checks++;
        if ({cap_res[8], cap_res[6], cap_res[5], sunk_p1} !== 5'b11001) begin
            failures++;
            $display("FAIL sink_third hit_sunk_ship_p1=%b exp=11001",
                     {cap_res[8], cap_res[6], cap_res[5], sunk_p1});
        end
    endtask

    task automatic test_game_over();
        int tr [4] = '{1, 3, 1, 4};
        int tc [4] = '{1, 5, 1, 5};
        int rv_seen;
        for (int i = 0; i < 4; i++) begin
            do_shot(tr[i], tc[i]);
            model_shot(tr[i], tc[i]);
            checks++;
            if (cap_res !== exp_res() || cap_post !== exp_post()) begin
                failures++;
                $display("FAIL over_%0d got=%b/%b exp=%b/%b", i, cap_res, cap_post,
                         exp_res(), exp_post());
            end
            if (i == 0) begin
                checks++;
                if (cap_res[2:1] !== 2'b01) begin
                    failures++;
                    $display("FAIL sunk_sticky sunk_p1=%b exp=01", cap_res[2:1]);
                end
            end
        end
        checks++;
        if ({cap_res[6], sunk_p1, cap_post} !== 8'b1_11_00010) begin
            failures++;
            $display("FAIL over_fixed got=%b exp=11100010", {cap_res[6], sunk_p1, cap_post});
        end
        rv_seen    = 0;
        shot_valid = 1'b1;
        shot_row   = 3'd0;
        shot_col   = 3'd0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (result_valid === 1'b1) rv_seen++;
        end
        shot_valid = 1'b0;
        checks++;
        if (rv_seen !== 0 || shot_ready !== 1'b0 || game_over !== 1'b1) begin
            failures++;
            $display("FAIL over_hold rv_seen=%0d ready=%b over=%b exp=0,0,1",
                     rv_seen, shot_ready, game_over);
        end
    endtask

    task automatic test_async_reset();
        int tr [6] = '{0, 1, 0, 1, 0, 7};
        int tc [6] = '{0, 1, 1, 1, 2, 0};
        int rv_seen;
        do_reset();
        place_std(12);
        pulse_start();
        for (int i = 0; i < 6; i++) begin
            do_shot(tr[i], tc[i]);
            model_shot(tr[i], tc[i]);
            checks++;
            if (cap_res !== exp_res() || cap_post !== exp_post()) begin
                failures++;
                $display("FAIL arst_pre_%0d got=%b/%b exp=%b/%b", i, cap_res, cap_post,
                         exp_res(), exp_post());
            end
        end
        shot_valid = 1'b1;
        shot_row   = 3'd2;
        shot_col   = 3'd5;
        @(negedge clk);
        shot_valid = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        model_clear();
        all_out = {shot_ready, turn, result_valid, result_hit, result_repeat, result_sunk,
                   result_ship, sunk_p0, sunk_p1, game_over, winner};
        checks++;
        if (all_out !== 13'd0) begin
            failures++;
            $display("FAIL arst_outputs got=%b exp=0", all_out);
        end
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        rv_seen = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (result_valid === 1'b1) rv_seen++;
        end
        checks++;
        if (rv_seen !== 0) begin
            failures++;
            $display("FAIL arst_no_result rv_seen=%0d exp=0", rv_seen);
        end
        pulse_start();
        checks++;
        if (shot_ready !== 1'b0) begin
            failures++;
            $display("FAIL arst_cleared shot_ready=%b exp=0", shot_ready);
        end
        place_std(12);
        pulse_start();
        checks++;
        if ({shot_ready, turn} !== 2'b10) begin
            failures++;
            $display("FAIL arst_replaced ready_turn=%b exp=10", {shot_ready, turn});
        end
    endtask

    task automatic test_random();
        int o, s, g, r, c, p, ps, pg;
        for (int game = 0; game < 3; game++) begin
            do_reset();
            for (int i = 0; i < 12; i++) begin
                p = i / 6;
                s = (i / 3) % 2;
                g = i % 3;
                r = $urandom_range(0, 7);
                c = $urandom_range(0, 7);
                // Sometimes stack a segment on the previous one of the same fleet.
                if (i % 6 != 0 && $urandom_range(0, 3) == 0) begin
                    ps = ((i - 1) / 3) % 2;
                    pg = (i - 1) % 3;
                    r  = m_row[p][ps][pg];
                    c  = m_col[p][ps][pg];
                end
                place(p, s, g, r, c, 1'b0);
            end
            for (int k = 0; k < 2; k++)
                place($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 2),
                      $urandom_range(0, 7), $urandom_range(0, 7), 1'b0);
            place($urandom_range(0, 1), $urandom_range(0, 1), 3,
                  $urandom_range(0, 7), $urandom_range(0, 7), 1'b0);
            pulse_start();
            checks++;
            if (shot_ready !== 1'b1) begin
                failures++;
                $display("FAIL rand_start_%0d shot_ready=%b exp=1", game, shot_ready);
            end
            for (int n = 0; n < 300 && !m_over; n++) begin
                if ($urandom_range(0, 3) == 0) begin
                    place_valid  = 1'b1;
                    start        = 1'b1;
                    place_player = 1'($urandom_range(0, 1));
                    place_ship   = 1'($urandom_range(0, 1));
                    place_seg    = 2'($urandom_range(0, 2));
                    place_row    = 3'($urandom_range(0, 7));
                    place_col    = 3'($urandom_range(0, 7));
                    @(negedge clk);
                    place_valid = 1'b0;
                    start       = 1'b0;
                end
                o = 1 - int'(m_turn);
                if ($urandom_range(0, 1) == 1) begin
                    s = $urandom_range(0, 1);
                    g = $urandom_range(0, 2);
                    r = m_row[o][s][g];
                    c = m_col[o][s][g];
                end else begin
                    r = $urandom_range(0, 7);
                    c = $urandom_range(0, 7);
                end
                do_shot(r, c);
                model_shot(r, c);
                checks++;
                if (cap_res !== exp_res() || cap_post !== exp_post()) begin
                    failures++;
                    $display("FAIL rand_g%0d_s%0d shot=(%0d,%0d) got=%b/%b exp=%b/%b",
                             game, n, r, c, cap_res, cap_post, exp_res(), exp_post());
                end
            end
            checks++;
            if (game_over !== m_over || winner !== m_winner) begin
                failures++;
                $display("FAIL rand_end_%0d over_winner=%b%b exp=%b%b", game, game_over,
                         winner, m_over, m_winner);
            end
        end
    endtask

    initial begin
        test_reset();
        test_setup_gating();
        test_miss();
        test_hit_repeat();
        test_sink();
        test_game_over();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

endmodule

// File: doc/battle_turn_controller.md
# battle_turn_controller

Turn sequencer for the two-player battleships datapath. It holds ship segment placements for both fleets and accepts shots from the active player. It resolves each shot against the opponent's segments, keeps per-segment hit bits and sticky per-ship sunk flags, and ends the game when one fleet is fully sunk. It sits between the player input/UI logic and the board display, and it absorbs the per-ship sunk tracking.

## Interface
- `NUM_SHIPS`, default 2: ships per player.
- `SHIP_SIZE`, default 3: segments per ship.
- `COORD_W`, default 3: row/column width (8x8 board).
- Derived: `SHIP_W` = max(1, clog2(NUM_SHIPS)), `SEG_W` = max(1, clog2(SHIP_SIZE)).

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset_n`  in  1  asynchronous reset, active low.
- `place_valid`  in  1  write one segment coordinate (SETUP only).
- `place_player`  in  1  fleet being written (0/1).
- `place_ship`  in  SHIP_W  ship index.
- `place_seg`  in  SEG_W  segment index.
- `place_row`, `place_col`  in  COORD_W each  segment coordinate.
- `start`  in  1  begin game (SETUP only).
- `shot_valid`  in  1  active player presents a shot.
- `shot_ready`  out  1  controller accepts a shot this cycle.
- `shot_row`, `shot_col`  in  COORD_W each  target cell.
- `turn`  out  1  active player.
- `result_valid`  out  1  one-cycle pulse per resolved shot.
- `result_hit`  out  1  shot matched a not-yet-hit segment.
- `result_repeat`  out  1  shot matched only already-hit segments.
- `result_sunk`  out  1  this shot sank a ship.
- `result_ship`  out  SHIP_W  lowest-index ship matched (0 on miss).
- `sunk_p0`, `sunk_p1`  out  NUM_SHIPS each  sticky sunk flags per fleet.
- `game_over`  out  1  game ended.
- `winner`  out  1  player who sank the opposing fleet; valid while game_over.

## Operation
- States: SETUP, SHOT, CHECK, REPORT, OVER.
- On reset_n low, all of the following are forced immediately:
  - state = SETUP.
  - All outputs = 0.
  - All coordinates, placed bits and hit bits = 0.
- **SETUP:**
  - place_valid writes the addressed coordinate and sets its placed bit. Rewriting overwrites.
  - Out-of-range place_ship/place_seg indices are ignored.
  - start moves to SHOT with turn = 0, but only if every placed bit of both fleets is 1. Otherwise start is ignored.
- **SHOT:**
  - shot_ready = 1.
  - A handshake (shot_valid & shot_ready) latches shot_row/shot_col and moves to CHECK.
  - place_valid and start are ignored outside SETUP.
- **CHECK:**
  - Compare the latched shot against every segment of fleet `~turn`.
  - Set the hit bit of every matching segment. Overlapping placements all get hit.
  - Compute the registered result fields.
  - Set sunk flags for ships whose hit bits are now all 1.
  - Move to REPORT.
- **Result classification:**
  - hit = at least one matched segment was previously unhit.
  - repeat = matches exist, but all were already hit.
  - Miss = no match; hit = repeat = 0.
  - result_sunk = a sunk flag rose 0 to 1 in this CHECK.
- **REPORT:**
  - result_valid = 1 for exactly one cycle; the result fields hold until the next REPORT.
  - If the opponent's sunk mask is all ones: game_over = 1, winner = turn, move to OVER, and turn does not toggle.
  - Otherwise turn toggles (every resolved shot, including hit and repeat) and the state returns to SHOT.
- **OVER:** terminal. shot_ready = 0; all outputs hold until reset_n.
- Sunk flags never clear except on reset.

## Timing
- Handshake in cycle T:
  - CHECK in T+1.
  - result_valid and updated sunk flags in T+2.
  - turn toggles and game_over asserts at the end of T+2.
  - shot_ready returns in T+3.
- Throughput: one shot per 3 cycles.
- shot_ready is a registered state decode and does not depend combinationally on shot_valid.
- place write takes effect the next cycle. start sampled in the same cycle as the final place_valid sees the old placed bits, so it is ignored.
- Reset asserted mid-CHECK/REPORT aborts without a result_valid pulse.

## Test plan
- **Setup gating:** place 11 of 12 segments, pulse start -> stays in SETUP, shot_ready = 0. Place the last segment, pulse start -> shot_ready = 1 at the next cycle, turn = 0.
- **Miss:** P0 fires at an empty cell -> result_valid exactly 2 cycles after the handshake, hit = 0, repeat = 0, then turn = 1, shot_ready 3 cycles after the handshake.
- **Hit then repeat:** P0 hits P1 ship 1 segment (2,5) -> hit = 1, result_ship = 1. Later P0 fires (2,5) again -> repeat = 1, hit = 0, sunk unchanged, turn still toggles.
- **Sink:** hit all 3 segments of P1 ship 0 -> result_sunk = 1 only on the third hit; sunk_p1 = 01 and stays set.
- **Game over:** sink both P1 ships -> game_over = 1, winner = 0, turn stays 0, shot_ready = 0; further shot_valid produces no result_valid.
- **Async reset mid-game:** drop reset_n during CHECK -> all outputs 0 immediately, state SETUP, placements cleared, start ignored until re-placed.
